// File: rtl/edge_pkg.sv
// Shared types and helpers for the debounced edge-detector array.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // True when a debounced transition old_level -> new_level is reportable under mode.
    function automatic logic edge_qualify(input edge_mode_t mode,
                                          input logic       old_level,
                                          input logic       new_level);
        logic rise;
        logic fall;
        rise = ~old_level & new_level;
        fall = old_level & ~new_level;
        edge_qualify = 1'b0;
        case (mode)
            EDGE_OFF:  edge_qualify = 1'b0;
            EDGE_RISE: edge_qualify = rise;
            EDGE_FALL: edge_qualify = fall;
            EDGE_BOTH: edge_qualify = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: synchronizer, strobe-gated debounce counter, debounced level,
// qualified edge pulse and sticky pending flag.
module edge_channel
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       button,
    input  edge_mode_t mode,
    input  logic       clear,
    output logic       level,
    output logic       edge_pulse,
    output logic       pending
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   pend_q, pend_d;
    logic                   sync_c;
    logic                   flip_c;
    logic                   qual_c;

    assign sync_c = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], button};
        cnt_d   = cnt_q;
        level_d = level_q;
        flip_c  = 1'b0;

        // Debounce only advances on strobes; a bounce back discards the count.
        if (clk_en) begin
            if (sync_c == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                level_d = sync_c;
                cnt_d   = '0;
                flip_c  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        qual_c  = flip_c & edge_qualify(mode, level_q, sync_c);
        pulse_d = qual_c;
        pend_d  = qual_c | (pend_q & ~clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
        end
    end

    assign level      = level_q;
    assign edge_pulse = pulse_q;
    assign pending    = pend_q;

endmodule

// File: rtl/debounced_edge_array.sv
// N_CH independent debounced edge-detector channels with an aggregated pending flag.
module debounced_edge_array
    import edge_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [N_CH-1:0]   button,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clear,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   edge_pulse,
    output logic [N_CH-1:0]   pending,
    output logic              any_pending
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .clk_en     (clk_en),
            .button     (button[i]),
            .mode       (edge_mode_t'(mode[2*i +: 2])),
            .clear      (clear[i]),
            .level      (level[i]),
            .edge_pulse (edge_pulse[i]),
            .pending    (pending[i])
        );
    end

    assign any_pending = |pending;

endmodule

// File: doc/debounced_edge_array.md
# debounced_edge_array

- Multi-channel successor to the single-button edge detector.
- Per channel:
  - synchronizes a raw button/switch input;
  - debounces it over a programmable number of `clk_en` strobes;
  - reports a one-cycle edge pulse, qualified by a per-channel runtime mode (off/rising/falling/both);
  - holds a sticky pending flag until software/FSM clears it.
- Sits between the board input pins and the control FSMs that consume button events.

## Interface
Parameters:
- `N_CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchronizer flops per channel (≥2).
- `DB_CYCLES`, 3: consecutive `clk_en` strobes a changed input must stay stable before the debounced level flips (1..65535).

Ports:
- `clk` in 1: single system clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high; clears all state.
- `clk_en` in 1: debounce/edge strobe; synchronizer runs every `clk` regardless.
- `button` in N_CH: raw asynchronous inputs.
- `mode` in 2*N_CH: channel i uses bits [2i+1:2i], type `edge_mode_t`.
- `clear` in N_CH: per-channel pending clear, level-sensitive, sampled every `clk`.
- `level` out N_CH: debounced level.
- `edge_pulse` out N_CH: one-`clk` pulse on a qualified debounced edge.
- `pending` out N_CH: sticky qualified-edge flag.
- `any_pending` out 1: OR of `pending`.

## Operation
- **Synchronizer:** shifts `button[i]` through `SYNC_STAGES` flops every clk; the last stage is `sync[i]`.
- **Debounce counter** `cnt[i]` (width max(1,$clog2(DB_CYCLES))), acting only on cycles with `clk_en`=1:
  - `sync[i]`==`level[i]`: `cnt`←0.
  - `sync[i]`!=`level[i]` and `cnt`==DB_CYCLES-1: `level[i]`←`sync[i]`, `cnt`←0. The edge is detected this cycle.
  - Otherwise: `cnt`←`cnt`+1.
  - A bounce back to `level` before the threshold discards the partial count.
- **Edge qualification:** a detected flip is qualified if the mode allows its direction:
  - EDGE_OFF: none.
  - EDGE_RISE: 0→1.
  - EDGE_FALL: 1→0.
  - EDGE_BOTH: both directions.
  - `mode` is sampled in the flip cycle. A mode change never creates or cancels an edge retroactively.
  - `level` tracks the input in every mode, including OFF.
- **edge_pulse[i]:** registered. High for exactly the one clk following the flip edge, then low on the next clk even if `clk_en`=0.
- **pending[i]:**
  - Set on the same edge as `edge_pulse[i]`.
  - Cleared on a clk edge where `clear[i]`=1 and no qualified edge is detected.
  - Simultaneous set and clear: set wins.
- **Channel independence:** channels are fully independent; no arbitration.
- **`any_pending`:** combinational OR of the registered `pending` bits.

## Timing
- **Reset:** while `rst` is high (asynchronous), all sync flops, `cnt`, `level`, `edge_pulse`, `pending` and `any_pending` are 0.
- **Button held high across reset:** reported as a rising edge after the full latency once `rst` drops.
- **Latency** (with `clk_en` tied 1): input stable from clk edge 0 sets `level` and `edge_pulse` at edge SYNC_STAGES+DB_CYCLES-1. With defaults that is edge 4.
- **Gated `clk_en`:** the debounce stage counts only strobed cycles; latency is SYNC_STAGES clks plus DB_CYCLES strobes.
- **Minimum spacing** between two edges on one channel: DB_CYCLES strobes.
- **Reset mid-count:** the partial count is discarded, with no pulse.
- **`clear` to `pending` low:** 1 clk.

## Structure
- Package `edge_pkg` holds:
  - `typedef enum logic [1:0] edge_mode_t {EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11}`;
  - function `edge_qualify(mode, old_level, new_level)`.
- Sub-module `edge_channel` contains one channel: synchronizer, counter, level, pulse and pending. It takes parameters SYNC_STAGES and DB_CYCLES.
- Top level generates `N_CH` instances and ORs `pending` into `any_pending`.

## Test plan
1. **Reset behaviour.** Reset with `button`=4'b0001 held and defaults, mode ch0=EDGE_RISE, `clk_en`=1, release `rst` at edge 0.
   - All outputs 0 during reset.
   - `level[0]`, `edge_pulse[0]` and `pending[0]` rise at edge 4.
   - `edge_pulse[0]` is low at edge 5.
2. **Bounce rejection.** ch1 toggles 0→1→0 with each level lasting 2 clks, DB_CYCLES=3.
   - `level[1]` stays 0, no pulse.
   - A subsequent stable 1 pulses once at the expected edge.
3. **Mode filtering.** Per mode, a 0→1 then 1→0 sequence on one channel, each level held ≥10 clks:
   - EDGE_FALL pulses only on 1→0;
   - EDGE_BOTH pulses twice;
   - EDGE_OFF never pulses, while `level` still follows the input.
4. **Clear semantics.** Assert `clear[2]` in the same cycle a qualified edge is detected.
   - `pending[2]` remains 1.
   - `clear[2]` one clk later drives `pending[2]` to 0 and `any_pending` to 0.
5. **`clk_en` gating.** `clk_en` high 1 cycle in 4, stable input change, DB_CYCLES=3.
   - Flip occurs on the 3rd strobe after the sync output changes.
   - `edge_pulse` is still exactly 1 clk wide.
6. **Mid-count reset.** Assert `rst` while `cnt`=2 (`level` 0, input 1).
   - No pulse is emitted.
   - After release the full latency restarts: the pulse appears at edge SYNC_STAGES+DB_CYCLES-1 measured from release.
